// File: rtl/rate_pkg.sv
// Shared types and defaults for the tick-rate sequencer slice.
// Holds FSM state codes, counter width and default reload periods.
package rate_pkg;

  localparam int CNT_W_DEF = 28;

  localparam int unsigned PERIOD0_DEF = 0;
  localparam int unsigned PERIOD1_DEF = 49999999;
  localparam int unsigned PERIOD2_DEF = 99999999;
  localparam int unsigned PERIOD3_DEF = 199999999;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic logic [3:0] digit_next(
    input logic [3:0] d,
    input logic       up
  );
    return up ? d + 4'd1 : d - 4'd1;
  endfunction

endpackage

// File: rtl/rate_sequencer_if.sv
// Control/status bundle between the switch inputs and the sequencer.
// master: speed_sel, run, step, dir, clear out; tick, digit, state in.
interface rate_sequencer_if;

  logic [1:0] speed_sel;
  logic       run;
  logic       step;
  logic       dir;
  logic       clear;
  logic       tick;
  logic [3:0] digit;
  logic [1:0] state;

  modport master (
    output speed_sel, run, step, dir, clear,
    input  tick, digit, state
  );

  modport slave (
    input  speed_sel, run, step, dir, clear,
    output tick, digit, state
  );

endinterface

// File: rtl/period_counter.sv
// Loadable down-counter shared by all tick rates.
// Ports: clk, load/load_val (priority), en (decrement), cnt, zero flag.
module period_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rate_sequencer.sv
// Tick-rate controller: run/hold/step/clear FSM driving a hex digit.
// Ports: clk, reset (sync, high), bus (slave: controls in, tick/digit/state out).
module rate_sequencer
  import rate_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned PERIOD0 = PERIOD0_DEF,
  parameter int unsigned PERIOD1 = PERIOD1_DEF,
  parameter int unsigned PERIOD2 = PERIOD2_DEF,
  parameter int unsigned PERIOD3 = PERIOD3_DEF
) (
  input logic             clk,
  input logic             reset,
  rate_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] P0 = CNT_W'(PERIOD0);
  localparam logic [CNT_W-1:0] P1 = CNT_W'(PERIOD1);
  localparam logic [CNT_W-1:0] P2 = CNT_W'(PERIOD2);
  localparam logic [CNT_W-1:0] P3 = CNT_W'(PERIOD3);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [1:0]       sel_q;
  logic [3:0]       digit_q;
  logic             tick_q;
  logic             adv;
  logic             ld;
  logic             en;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic             chg;

  always_comb begin
    ld_val = P0;
    unique case (bus.speed_sel)
      2'd0:    ld_val = P0;
      2'd1:    ld_val = P1;
      2'd2:    ld_val = P2;
      default: ld_val = P3;
    endcase
  end

  assign chg = (bus.speed_sel != sel_q);

  // Speed changes reload from the new period and swallow any step.
  // Outside a change sel_q == speed_sel, so ld_val serves every reload.
  always_comb begin
    ld      = 1'b0;
    en      = 1'b0;
    adv     = 1'b0;
    state_d = state_q;
    if (reset || bus.clear) begin
      ld      = 1'b1;
      state_d = S_IDLE;
    end else if (chg) begin
      ld = 1'b1;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          ld = 1'b1;
          if (bus.run) begin
            state_d = S_RUN;
          end else if (bus.step) begin
            adv = 1'b1;
          end
        end
        (state_q == S_RUN): begin
          if (zero) begin
            ld  = 1'b1;
            adv = 1'b1;
          end else begin
            en = 1'b1;
          end
          if (!bus.run) begin
            state_d = S_HOLD;
          end
        end
        (state_q == S_HOLD): begin
          if (bus.run) begin
            state_d = S_RUN;
          end else if (bus.step) begin
            adv = 1'b1;
          end
        end
        default: begin
          ld      = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= 1'b0;
      digit_q <= 4'd0;
      sel_q   <= bus.speed_sel;
    end else begin
      state_q <= state_d;
      tick_q  <= adv;
      sel_q   <= bus.speed_sel;
      if (bus.clear) begin
        digit_q <= 4'd0;
      end else if (adv) begin
        digit_q <= digit_next(digit_q, bus.dir);
      end
    end
  end

  assign bus.tick  = tick_q;
  assign bus.digit = digit_q;
  assign bus.state = state_q;

endmodule
